dmem_mmio: RTL

- Data-side memory subsystem directly downstream of the pipelined core's memory stage.
- Consumes the core's M-stage address, store data and write strobe; returns load data in the same cycle.
- Contains a word-addressed data RAM plus a memory-mapped I/O region:
  - GPIO output register
  - free-running cycle counter
  - UART transmitter with a small TX FIFO

---
 rtl/dmem_mmio.sv | 100 ++++++++++
 1 files changed

// File: rtl/dmem_mmio.sv
// dmem_mmio: M-stage data RAM plus GPIO/cycle-counter/UART-TX MMIO (clk, rst active-low async, addr, write_data, mem_write -> read_data, gpio_out, uart_tx)
module dmem_mmio #(
  parameter int RAM_AW = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int CLKS_PER_BIT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] addr,
  input  logic [31:0] write_data,
  input  logic        mem_write,
  output logic [31:0] read_data,
  output logic [7:0]  gpio_out,
  output logic        uart_tx
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CNTW = PW + 1;
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [1:0] IDLE = 2'd0, START = 2'd1, DATA = 2'd2, STOP = 2'd3;
  logic [31:0] ram [2**RAM_AW];
  logic [7:0] fifoMem [FIFO_DEPTH];
  logic [PW-1:0] wrPtr, rdPtr;
  logic [CNTW-1:0] count;
  logic overflow;
  logic [31:0] cycle;
  logic [1:0] state;
  logic [CW-1:0] bitTimer;
  logic [2:0] bitIdx;
  logic [7:0] shiftReg;
  logic isMmio, ramWe, gpioWe, cycleWe, dataWe, statWe;
  logic empty, full, busy, timerDone, pop, push;
  logic [31:0] statWord;
  always_comb begin
    isMmio = addr[31];
    ramWe = mem_write && !isMmio;
    gpioWe = mem_write && isMmio && addr[3:2] == 2'd0;
    cycleWe = mem_write && isMmio && addr[3:2] == 2'd1;
    dataWe = mem_write && isMmio && addr[3:2] == 2'd2;
    statWe = mem_write && isMmio && addr[3:2] == 2'd3;
    empty = count == '0;
    full = count == CNTW'(FIFO_DEPTH);
    busy = state != IDLE;
    timerDone = bitTimer == CW'(CLKS_PER_BIT - 1);
    pop = !empty && (state == IDLE || (state == STOP && timerDone));
    push = dataWe && (!full || pop);
    statWord = {23'd0, 5'(count), overflow, empty, full, busy};
    read_data = !isMmio ? ram[addr[RAM_AW+1:2]] :
                addr[3:2] == 2'd0 ? {24'd0, gpio_out} :
                addr[3:2] == 2'd1 ? cycle :
                addr[3:2] == 2'd2 ? 32'd0 : statWord;
    uart_tx = state == START ? 1'b0 : state == DATA ? shiftReg[0] : 1'b1;
  end
  always_ff @(posedge clk) begin
    if (ramWe) ram[addr[RAM_AW+1:2]] <= write_data;
  end
  always_ff @(posedge clk) begin
    if (push) fifoMem[wrPtr] <= write_data[7:0];
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      gpio_out <= '0;
      cycle <= '0;
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
      overflow <= 1'b0;
      state <= IDLE;
      bitTimer <= '0;
      bitIdx <= '0;
      shiftReg <= '0;
    end else begin
      if (gpioWe) gpio_out <= write_data[7:0];
      cycle <= cycleWe ? '0 : cycle + 32'd1;
      if (push) wrPtr <= wrPtr + PW'(1);
      if (pop) rdPtr <= rdPtr + PW'(1);
      count <= count + CNTW'(push) - CNTW'(pop);
      overflow <= statWe ? 1'b0 : overflow || (dataWe && !push);
      bitTimer <= (state == IDLE || timerDone) ? '0 : bitTimer + CW'(1);
      case (state)
        IDLE: if (pop) begin
          shiftReg <= fifoMem[rdPtr];
          state <= START;
        end
        START: if (timerDone) begin
          state <= DATA;
          bitIdx <= '0;
        end
        DATA: if (timerDone) begin
          shiftReg <= shiftReg >> 1;
          bitIdx <= bitIdx + 3'd1;
          if (bitIdx == 3'd7) state <= STOP;
        end
        default: if (timerDone) begin
          state <= pop ? START : IDLE;
          if (pop) shiftReg <= fifoMem[rdPtr];
        end
      endcase
    end
  end
endmodule
